// File: rtl/conv_result_serializer_if.sv
// Handshake bundle of the convolution result serializer: parallel word in, bit-serial stream out.
// slave is the serializer's view, master the producer/consumer side.
interface conv_result_serializer_if #(
  parameter int unsigned OUTLEN = 257
);
  logic              in_valid;
  logic              in_ready;
  logic [OUTLEN-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bit, out_last, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bit, out_last, busy
  );
endinterface

// File: rtl/conv_result_serializer.sv
// Captures one GF(2) convolution result word and streams it out one bit per beat with a last marker.
// Optional macro CONV_SER_PARITY_EN appends an even-parity beat after the data bits of every frame.
module conv_result_serializer #(
  parameter int unsigned INLEN     = 255,
  parameter int unsigned KERNLEN   = 3,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  conv_result_serializer_if.slave bus
);
  localparam int unsigned   OUTLEN   = INLEN + KERNLEN - 1;
  localparam int unsigned   CW       = $clog2(OUTLEN + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(OUTLEN - 1);

`ifdef CONV_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state;
  logic [OUTLEN-1:0] sreg;
  logic [OUTLEN-1:0] sreg_adv;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              valid_q;
  logic              bit_q;
  logic              last_q;
  logic              busy_q;
  logic              ready_c;
  logic              accept_c;
  logic              beat_c;
`ifdef CONV_SER_PARITY_EN
  logic              parity;
`endif

  // Bit presented first from a word, honouring the serial order.
  function automatic logic head_bit(input logic [OUTLEN-1:0] w);
    return MSB_FIRST ? w[OUTLEN-1] : w[0];
  endfunction

  // Ready in IDLE, or on the beat that closes a frame so the next word follows with no bubble.
  assign ready_c  = !rst && ((state == IDLE) || (valid_q && bus.out_ready && last_q));
  assign accept_c = bus.in_valid && ready_c;
  assign beat_c   = valid_q && bus.out_ready;
  assign sreg_adv = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
  assign cnt_inc  = cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CONV_SER_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (accept_c) begin
      state   <= SHIFT;
      sreg    <= bus.in_data;
      cnt     <= '0;
      valid_q <= 1'b1;
      busy_q  <= 1'b1;
      bit_q   <= head_bit(bus.in_data);
      last_q  <= !PAR_EN && (LAST_IDX == '0);
`ifdef CONV_SER_PARITY_EN
      parity  <= ^bus.in_data;
`endif
    end else if (beat_c) begin
      if (last_q) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        bit_q   <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end
`ifdef CONV_SER_PARITY_EN
      else if (cnt == LAST_IDX) begin
        state  <= PAR;
        cnt    <= cnt_inc;
        bit_q  <= parity;
        last_q <= 1'b1;
      end
`endif
      else begin
        sreg   <= sreg_adv;
        cnt    <= cnt_inc;
        bit_q  <= head_bit(sreg_adv);
        last_q <= !PAR_EN && (cnt_inc == LAST_IDX);
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_bit   = bit_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_conv_result_serializer.sv
// Bench for conv_result_serializer: LSB-first and MSB-first instances driven in lockstep,
// a directed vector table, hand-written corner sequences and a random run against a queue model.
module tb_conv_result_serializer;
  localparam int unsigned INLEN   = 3;
  localparam int unsigned KERNLEN = 3;
  localparam int unsigned OUTLEN  = INLEN + KERNLEN - 1;
`ifdef CONV_SER_PARITY_EN
  localparam int unsigned NBEATS = OUTLEN + 1;
  localparam bit          PAR_EN = 1'b1;
`else
  localparam int unsigned NBEATS = OUTLEN;
  localparam bit          PAR_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic [OUTLEN-1:0] in_data;
  int                tests = 0;
  int                fails = 0;

  conv_result_serializer_if #(.OUTLEN(OUTLEN)) bl ();
  conv_result_serializer_if #(.OUTLEN(OUTLEN)) bm ();

  assign bl.in_valid  = in_valid;
  assign bl.in_data   = in_data;
  assign bl.out_ready = out_ready;
  assign bm.in_valid  = in_valid;
  assign bm.in_data   = in_data;
  assign bm.out_ready = out_ready;

  conv_result_serializer #(.INLEN(INLEN), .KERNLEN(KERNLEN), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .bus(bl.slave)
  );
  conv_result_serializer #(.INLEN(INLEN), .KERNLEN(KERNLEN), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .bus(bm.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic ov [2];
  logic ob [2];
  logic ol [2];
  logic ir [2];
  logic bz [2];
  assign ov[0] = bl.out_valid;  assign ov[1] = bm.out_valid;
  assign ob[0] = bl.out_bit;    assign ob[1] = bm.out_bit;
  assign ol[0] = bl.out_last;   assign ol[1] = bm.out_last;
  assign ir[0] = bl.in_ready;   assign ir[1] = bm.in_ready;
  assign bz[0] = bl.busy;       assign bz[1] = bm.busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each instance owns a queue of bits still to be sent; the head is on the wire.
  bit mq [2][$];
  bit m_ir;
  int m_n;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mq[d].delete();
        check($sformatf("model%0d rst out_valid", d), ov[d], 0);
        check($sformatf("model%0d rst in_ready", d), ir[d], 0);
        check($sformatf("model%0d rst busy", d), bz[d], 0);
      end else begin
        m_n  = mq[d].size();
        m_ir = (m_n == 0) || (m_n == 1 && out_ready);
        check($sformatf("model%0d in_ready", d), ir[d], m_ir);
        check($sformatf("model%0d out_valid", d), ov[d], m_n != 0);
        check($sformatf("model%0d busy", d), bz[d], m_n != 0);
        if (m_n != 0) begin
          check($sformatf("model%0d out_bit", d), ob[d], mq[d][0]);
          check($sformatf("model%0d out_last", d), ol[d], m_n == 1);
          if (out_ready) void'(mq[d].pop_front());
        end
        if (in_valid && m_ir) begin
          for (int i = 0; i < OUTLEN; i++)
            mq[d].push_back(d == 1 ? in_data[OUTLEN-1-i] : in_data[i]);
`ifdef CONV_SER_PARITY_EN
          mq[d].push_back(^in_data);
`endif
        end
      end
    end
  end

  typedef struct {
    logic              iv;
    logic [OUTLEN-1:0] d;
    logic              ordy;
    logic              ov;
    logic              ob;
    logic              ol;
    logic              ir;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic iv, input logic [OUTLEN-1:0] d, input logic ordy,
                     input logic e_ov, input logic e_ob, input logic e_ol, input logic e_ir);
    vecs.push_back('{iv, d, ordy, e_ov, e_ob, e_ol, e_ir});
  endtask

  // One accepted beat with out_ready high; in_ready rises only on the closing beat.
  task automatic beat(input logic iv, input logic [OUTLEN-1:0] d, input logic b, input logic last);
    add(iv, d, 1'b1, 1'b1, b, last, last);
  endtask

  task automatic fin(input logic iv, input logic [OUTLEN-1:0] d, input logic b, input logic par);
    if (PAR_EN) begin
      beat(iv, d, b, 1'b0);
      beat(iv, d, par, 1'b1);
    end else begin
      beat(iv, d, b, 1'b1);
    end
  endtask

  // Sends one word with out_ready held high and checks the beats seen on both instances.
  task automatic run_frame(input string name, input logic [OUTLEN-1:0] w,
                           input logic [OUTLEN-1:0] lv, input logic [OUTLEN-1:0] mv, input logic par);
    logic [NBEATS-1:0] got_l, got_m, exp_l, exp_m;
    int nl, nm, last_l, lasts;
    bit done;
    exp_l = NBEATS'({par, lv});
    exp_m = NBEATS'({par, mv});
    got_l = '0; got_m = '0; nl = 0; nm = 0; last_l = -1; lasts = 0; done = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = w; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = OUTLEN'($urandom);
    for (int c = 0; c < 4 * NBEATS && !done; c++) begin
      @(negedge clk);
      if (bl.out_valid) begin
        if (nl < NBEATS) got_l[nl] = bl.out_bit;
        if (bl.out_last) begin last_l = nl; lasts++; end
        nl++;
        done = bl.out_last;
      end
      if (bm.out_valid) begin
        if (nm < NBEATS) got_m[nm] = bm.out_bit;
        nm++;
      end
    end
    check({name, " frame ended"}, done, 1);
    check({name, " lsb beat count"}, nl, NBEATS);
    check({name, " msb beat count"}, nm, NBEATS);
    check({name, " lsb bits"}, got_l, exp_l);
    check({name, " msb bits"}, got_m, exp_m);
    check({name, " last position"}, last_l, NBEATS - 1);
    check({name, " last count"}, lasts, 1);
    @(negedge clk);
    check({name, " out_valid after"}, bl.out_valid, 0);
    check({name, " in_ready after"}, bl.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", tests);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d out_valid", d), ov[d], 0);
      check($sformatf("reset%0d out_bit", d), ob[d], 0);
      check($sformatf("reset%0d out_last", d), ol[d], 0);
      check($sformatf("reset%0d busy", d), bz[d], 0);
      check($sformatf("reset%0d in_ready", d), ir[d], 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", bl.in_ready, 1);

    // Directed table for the LSB-first instance.
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 5'b11011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    beat(1'b0, '0, 1'b1, 1'b0); beat(1'b0, '0, 1'b1, 1'b0);
    beat(1'b0, '0, 1'b0, 1'b0); beat(1'b0, '0, 1'b1, 1'b0);
    fin(1'b0, '0, 1'b1, 1'b0);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Back-to-back frames: 00001 then 10000 with in_valid held high.
    add(1'b1, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 5'b10000, 1'b1, 1'b0); beat(1'b1, 5'b10000, 1'b0, 1'b0);
    beat(1'b1, 5'b10000, 1'b0, 1'b0); beat(1'b1, 5'b10000, 1'b0, 1'b0);
    fin(1'b1, 5'b10000, 1'b0, 1'b1);
    beat(1'b0, '0, 1'b0, 1'b0); beat(1'b0, '0, 1'b0, 1'b0);
    beat(1'b0, '0, 1'b0, 1'b0); beat(1'b0, '0, 1'b0, 1'b0);
    fin(1'b0, '0, 1'b1, 1'b1);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Backpressure on beat 2 of 01010 for three cycles.
    add(1'b1, 5'b01010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    beat(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 5'b11111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b0, '0, 1'b1, 1'b0); beat(1'b0, '0, 1'b0, 1'b0); beat(1'b0, '0, 1'b1, 1'b0);
    fin(1'b0, '0, 1'b0, 1'b0);
    add(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("tbl[%0d] out_valid", i), bl.out_valid, vecs[i].ov);
      check($sformatf("tbl[%0d] in_ready", i), bl.in_ready, vecs[i].ir);
      if (vecs[i].ov) begin
        check($sformatf("tbl[%0d] out_bit", i), bl.out_bit, vecs[i].ob);
        check($sformatf("tbl[%0d] out_last", i), bl.out_last, vecs[i].ol);
      end
    end

    // Whole frames on both instances, including the serial-order and parity cases.
    run_frame("w11011", 5'b11011, 5'b11011, 5'b11011, 1'b0);
    run_frame("w10010", 5'b10010, 5'b10010, 5'b01001, 1'b0);
    run_frame("w00111", 5'b00111, 5'b00111, 5'b11100, 1'b1);

    // Reset in the middle of beat 3 discards the frame at once.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 5'b01010; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("midrst beat3 out_valid", bl.out_valid, 1);
    check("midrst beat3 out_bit", bl.out_bit, 0);
    rst = 1'b1; #1;
    check("midrst lsb out_valid", bl.out_valid, 0);
    check("midrst lsb busy", bl.busy, 0);
    check("midrst msb out_valid", bm.out_valid, 0);
    check("midrst in_ready", bl.in_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 check("midrst release in_ready", bl.in_ready, 1);
    run_frame("w11111", 5'b11111, 5'b11111, 5'b11111, 1'b1);

    // Random traffic with random backpressure and occasional resets, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = OUTLEN'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3 * NBEATS) @(posedge clk);
    @(negedge clk);
    check("final idle busy", bl.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
